// File: rtl/eth_rx_frame_ctrl_pkg.sv
// Shared types and constants for the Ethernet receive frame controller.
// The state encoding is also used by the testbench for readability.
package eth_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT,
        S_DST,
        S_SRC,
        S_TYPE,
        S_PAYLOAD,
        S_GAP
    } eth_rx_state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_NO_SFD  = 3'd1;
    localparam logic [2:0] ERR_HDR_TO  = 3'd2;
    localparam logic [2:0] ERR_TRUNC   = 3'd3;
    localparam logic [2:0] ERR_RUNT    = 3'd4;
    localparam logic [2:0] ERR_GIANT   = 3'd5;

    localparam int PAYLOAD_LEN_W = 11;
    localparam int STAT_W        = 16;
    localparam int CNT_W         = 8;

endpackage

// File: rtl/eth_rx_frame_ctrl_if.sv
// Byte-stream, parser-pulse and status bundle of the frame controller.
// slave is the controller side, master the MAC/parser/monitor side.
interface eth_rx_frame_ctrl_if;
    import eth_rx_pkg::*;

    logic                     rx_dv;
    logic                     preamble_valid;
    logic                     dst_addr_valid;
    logic                     src_addr_valid;
    logic                     type_length_valid;
    logic                     parser_enable;
    logic                     busy;
    logic                     hdr_ok;
    logic                     frame_done;
    logic                     frame_err;
    logic [2:0]               err_code;
    logic [PAYLOAD_LEN_W-1:0] payload_len;
    logic [STAT_W-1:0]        good_cnt;
    logic [STAT_W-1:0]        err_cnt;

    modport slave (
        input  rx_dv, preamble_valid, dst_addr_valid,
        input  src_addr_valid, type_length_valid,
        output parser_enable, busy, hdr_ok, frame_done,
        output frame_err, err_code, payload_len,
        output good_cnt, err_cnt
    );

    modport master (
        output rx_dv, preamble_valid, dst_addr_valid,
        output src_addr_valid, type_length_valid,
        input  parser_enable, busy, hdr_ok, frame_done,
        input  frame_err, err_code, payload_len,
        input  good_cnt, err_cnt
    );

endinterface

// File: rtl/eth_rx_frame_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module eth_sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// Ethernet RX frame controller: header-parser sequencing, payload length, IFG.
// Optional ETH_RX_STATS_EN adds saturating good/errored frame counters.
module eth_rx_frame_ctrl
    import eth_rx_pkg::*;
#(
    parameter int FIELD_TO    = 8,
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500,
    parameter int IFG_CYCLES  = 12
) (
    input  logic                clock,
    input  logic                reset_n,
    eth_rx_frame_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(FIELD_TO - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);
    localparam logic [PAYLOAD_LEN_W-1:0] MIN_L = PAYLOAD_LEN_W'(MIN_PAYLOAD);
    localparam logic [PAYLOAD_LEN_W-1:0] MAX_L = PAYLOAD_LEN_W'(MAX_PAYLOAD);

    eth_rx_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       fld_hit;
    logic       ev_hdr;
    logic       ev_end;
    logic [2:0] ev_code;

    logic [PAYLOAD_LEN_W-1:0] len_cnt;

    logic                     pe_q, pe_d;
    logic                     busy_q, busy_d;
    logic                     hdr_q, hdr_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [2:0]               code_q, code_d;
    logic [PAYLOAD_LEN_W-1:0] len_q, len_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        fld_hit = 1'b0;
        unique case (1'b1)
            state_q == S_DST:  fld_hit = bus.dst_addr_valid;
            state_q == S_SRC:  fld_hit = bus.src_addr_valid;
            state_q == S_TYPE: fld_hit = bus.type_length_valid;
            default:           fld_hit = 1'b0;
        endcase
    end

    // Header priority: expected pulse, then rx_dv drop, then deadline.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ev_hdr  = 1'b0;
        ev_end  = 1'b0;
        ev_code = ERR_NONE;
        unique case (state_q)
            S_IDLE: begin
                if (bus.rx_dv) begin
                    state_d = S_HUNT;
                    cnt_d   = '0;
                end
            end
            S_HUNT: begin
                if (bus.preamble_valid) begin
                    state_d = S_DST;
                    cnt_d   = '0;
                end else if (!bus.rx_dv) begin
                    ev_end  = 1'b1;
                    ev_code = ERR_NO_SFD;
                end
            end
            S_DST, S_SRC, S_TYPE: begin
                if (fld_hit) begin
                    cnt_d  = '0;
                    ev_hdr = (state_q == S_TYPE);
                    state_d = (state_q == S_DST) ? S_SRC :
                              (state_q == S_SRC) ? S_TYPE : S_PAYLOAD;
                end else if (!bus.rx_dv) begin
                    ev_end  = 1'b1;
                    ev_code = ERR_TRUNC;
                end else if (cnt_q == TO_LAST) begin
                    ev_end  = 1'b1;
                    ev_code = ERR_HDR_TO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (!bus.rx_dv) begin
                    ev_end = 1'b1;
                    if (len_cnt < MIN_L)
                        ev_code = ERR_RUNT;
                    else if (len_cnt > MAX_L)
                        ev_code = ERR_GIANT;
                end
            end
            S_GAP: begin
                if (cnt_q == IFG_LAST)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (ev_end) begin
            state_d = S_GAP;
            cnt_d   = '0;
        end
    end

    always_comb begin
        pe_d   = state_d inside {S_HUNT, S_DST, S_SRC, S_TYPE};
        busy_d = (state_d != S_IDLE);
        hdr_d  = ev_hdr;
        done_d = ev_end && (ev_code == ERR_NONE);
        err_d  = ev_end && (ev_code != ERR_NONE);
        code_d = code_q;
        len_d  = len_q;
        if (ev_end) begin
            code_d = ev_code;
            len_d  = (state_q == S_PAYLOAD) ? len_cnt : '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pe_q   <= 1'b0;
            busy_q <= 1'b0;
            hdr_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
            len_q  <= '0;
        end else begin
            pe_q   <= pe_d;
            busy_q <= busy_d;
            hdr_q  <= hdr_d;
            done_q <= done_d;
            err_q  <= err_d;
            code_q <= code_d;
            len_q  <= len_d;
        end
    end

    eth_sat_counter #(.W(PAYLOAD_LEN_W)) u_len (
        .clock   (clock),
        .reset_n (reset_n),
        .clr_i   (ev_hdr),
        .inc_i   ((state_q == S_PAYLOAD) && bus.rx_dv),
        .cnt_o   (len_cnt)
    );

`ifdef ETH_RX_STATS_EN
    logic [STAT_W-1:0] good_cnt, err_cnt;

    eth_sat_counter #(.W(STAT_W)) u_good (
        .clock   (clock),
        .reset_n (reset_n),
        .clr_i   (1'b0),
        .inc_i   (done_d),
        .cnt_o   (good_cnt)
    );

    eth_sat_counter #(.W(STAT_W)) u_err (
        .clock   (clock),
        .reset_n (reset_n),
        .clr_i   (1'b0),
        .inc_i   (err_d),
        .cnt_o   (err_cnt)
    );

    assign bus.good_cnt = good_cnt;
    assign bus.err_cnt  = err_cnt;
`else
    assign bus.good_cnt = '0;
    assign bus.err_cnt  = '0;
`endif

    assign bus.parser_enable = pe_q;
    assign bus.busy          = busy_q;
    assign bus.hdr_ok        = hdr_q;
    assign bus.frame_done    = done_q;
    assign bus.frame_err     = err_q;
    assign bus.err_code      = code_q;
    assign bus.payload_len   = len_q;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Testbench for eth_rx_frame_ctrl: frame-end scoreboard plus per-scenario tasks.
module tb_eth_rx_frame_ctrl;
    import eth_rx_pkg::*;

    typedef struct packed {
        logic        good;
        logic [2:0]  code;
        logic [10:0] len;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   hdr_seen = 0;
    exp_t exp_q[$];

    eth_rx_frame_ctrl_if bus ();

    eth_rx_frame_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Scoreboard: every frame end is matched against the oldest expectation.
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.hdr_ok)
                hdr_seen++;
            if (bus.frame_done || bus.frame_err) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_end done=%0b err=%0b code=%0d required none",
                             bus.frame_done, bus.frame_err, bus.err_code);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus.frame_done !== e.good || bus.frame_err !== !e.good ||
                        bus.err_code !== e.code || bus.payload_len !== e.len)
                        $display("FAIL frame_end got done=%0b err=%0b code=%0d len=%0d required done=%0b code=%0d len=%0d",
                                 bus.frame_done, bus.frame_err, bus.err_code,
                                 bus.payload_len, e.good, e.code, e.len);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic drive(input logic dv, input logic pre, input logic dst,
                         input logic src, input logic typ);
        bus.rx_dv             = dv;
        bus.preamble_valid    = pre;
        bus.dst_addr_valid    = dst;
        bus.src_addr_valid    = src;
        bus.type_length_valid = typ;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_end(input logic good, input logic [2:0] code,
                              input int len);
        exp_t e;
        e.good = good;
        e.code = code;
        e.len  = 11'(len);
        exp_q.push_back(e);
    endtask

    task automatic send_hdr(input logic last_dv);
        repeat (7) drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        repeat (5) drive(1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        repeat (5) drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0);
        drive(last_dv, 0, 0, 0, 1);
    endtask

    task automatic send_frame(input int npay);
        send_hdr(1'b1);
        repeat (npay) drive(1, 0, 0, 0, 0);
    endtask

    task automatic settle();
        int n = 0;
        while ((bus.busy || exp_q.size() != 0) && n < 200) begin
            drive(0, 0, 0, 0, 0);
            n++;
        end
        if (n >= 200) begin
            n_chk++;
            $display("FAIL settle_timeout busy=%0b pending=%0d required idle",
                     bus.busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        bus.rx_dv = 0;
        bus.preamble_valid = 0;
        bus.dst_addr_valid = 0;
        bus.src_addr_valid = 0;
        bus.type_length_valid = 0;
        reset_n = 0;
        repeat (3) @(posedge clock);
        #1;
        n_chk++;
        if ({bus.parser_enable, bus.busy, bus.hdr_ok, bus.frame_done,
             bus.frame_err, bus.err_code, bus.payload_len,
             bus.good_cnt, bus.err_cnt} !== '0)
            $display("FAIL reset_state pe=%0b busy=%0b code=%0d len=%0d required all 0",
                     bus.parser_enable, bus.busy, bus.err_code, bus.payload_len);
        else
            n_pass++;
        reset_n = 1;
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_good_frame();
        int h0 = hdr_seen;
        int n = 0;
        bit pe_low = 1;
        send_frame(46);
        expect_end(1, ERR_NONE, 46);
        drive(0, 0, 0, 0, 0);
        n_chk++;
        if (bus.frame_done !== 1'b1)
            $display("FAIL good_done got %0b required 1", bus.frame_done);
        else
            n_pass++;
        while (bus.busy && n < 40) begin
            if (bus.parser_enable !== 1'b0) pe_low = 0;
            drive(0, 0, 0, 0, 0);
            n++;
        end
        n_chk++;
        if (n !== 12 || !pe_low)
            $display("FAIL gap_len got %0d pe_low=%0b required 12 and 1", n, pe_low);
        else
            n_pass++;
        n_chk++;
        if (hdr_seen - h0 !== 1)
            $display("FAIL good_hdr_ok got %0d required 1", hdr_seen - h0);
        else
            n_pass++;
        settle();
    endtask

    task automatic test_runt_giant();
        send_frame(45);
        expect_end(0, ERR_RUNT, 45);
        drive(0, 0, 0, 0, 0);
        settle();
        send_frame(1501);
        expect_end(0, ERR_GIANT, 1501);
        drive(0, 0, 0, 0, 0);
        settle();
        send_frame(2100);
        expect_end(0, ERR_GIANT, 2047);
        drive(0, 0, 0, 0, 0);
        settle();
    endtask

    task automatic test_timeout();
        repeat (7) drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        repeat (7) drive(1, 0, 0, 0, 0);
        expect_end(0, ERR_HDR_TO, 0);
        drive(1, 0, 0, 0, 0);
        n_chk++;
        if (bus.frame_err !== 1'b1 || bus.busy !== 1'b1 || bus.parser_enable !== 1'b0)
            $display("FAIL timeout_gap err=%0b busy=%0b pe=%0b required 1 1 0",
                     bus.frame_err, bus.busy, bus.parser_enable);
        else
            n_pass++;
        repeat (20) drive(1, 0, 0, 0, 0);
        n_chk++;
        if (bus.err_code !== ERR_HDR_TO || bus.parser_enable !== 1'b1)
            $display("FAIL timeout_hold code=%0d pe=%0b required 2 1",
                     bus.err_code, bus.parser_enable);
        else
            n_pass++;
        expect_end(0, ERR_NO_SFD, 0);
        drive(0, 0, 0, 0, 0);
        settle();
    endtask

    task automatic test_trunc();
        drive(1, 0, 0, 0, 0);
        n_chk++;
        if (bus.parser_enable !== 1'b1 || bus.busy !== 1'b1)
            $display("FAIL hunt_entry pe=%0b busy=%0b required 1 1",
                     bus.parser_enable, bus.busy);
        else
            n_pass++;
        repeat (6) drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        repeat (5) drive(1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        repeat (3) drive(1, 0, 0, 0, 0);
        expect_end(0, ERR_TRUNC, 0);
        drive(0, 0, 0, 0, 0);
        settle();
        repeat (10) drive(1, 0, 0, 0, 0);
        expect_end(0, ERR_NO_SFD, 0);
        drive(0, 0, 0, 0, 0);
        settle();
    endtask

    task automatic test_simultaneous();
        int h0 = hdr_seen;
        send_hdr(1'b0);
        expect_end(0, ERR_RUNT, 0);
        drive(0, 0, 0, 0, 0);
        settle();
        n_chk++;
        if (hdr_seen - h0 !== 1)
            $display("FAIL simul_hdr_ok got %0d required 1", hdr_seen - h0);
        else
            n_pass++;
    endtask

    task automatic test_reset_mid();
        send_frame(20);
        #3;
        reset_n = 0;
        #1;
        n_chk++;
        if ({bus.parser_enable, bus.busy, bus.hdr_ok, bus.frame_done,
             bus.frame_err, bus.err_code, bus.payload_len,
             bus.good_cnt, bus.err_cnt} !== '0)
            $display("FAIL reset_mid pe=%0b busy=%0b code=%0d len=%0d required all 0",
                     bus.parser_enable, bus.busy, bus.err_code, bus.payload_len);
        else
            n_pass++;
        bus.rx_dv = 0;
        @(posedge clock);
        #1;
        reset_n = 1;
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            send_frame(46 + i);
            expect_end(1, ERR_NONE, 46 + i);
            drive(0, 0, 0, 0, 0);
            settle();
        end
        for (int i = 0; i < 2; i++) begin
            send_frame(10 + i);
            expect_end(0, ERR_RUNT, 10 + i);
            drive(0, 0, 0, 0, 0);
            settle();
        end
        n_chk++;
`ifdef ETH_RX_STATS_EN
        if (bus.good_cnt !== 16'd3 || bus.err_cnt !== 16'd2)
            $display("FAIL stats got good=%0d err=%0d required 3 2",
                     bus.good_cnt, bus.err_cnt);
        else
            n_pass++;
`else
        if (bus.good_cnt !== 16'd0 || bus.err_cnt !== 16'd0)
            $display("FAIL stats_tied got good=%0d err=%0d required 0 0",
                     bus.good_cnt, bus.err_cnt);
        else
            n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_runt_giant();
        test_timeout();
        test_trunc();
        test_simultaneous();
        test_reset_mid();
        repeat (3) drive(0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_ctrl.md
# eth_rx_frame_ctrl

Receive-side frame controller that sequences the Ethernet header parser. It gates the parser's enable around each frame and tracks the parser's four field-valid pulses against per-field deadlines. After the header it counts payload bytes, then classifies the frame as good or errored and enforces an inter-frame gap that re-arms the parser. It sits between the MAC byte stream (rx_dv) and the header parser.

## Interface
- FIELD_TO, 8: max cycles allowed from one header-valid pulse to the next (DST, SRC, TYPE stages).
- MIN_PAYLOAD, 46: smallest legal payload byte count.
- MAX_PAYLOAD, 1500: largest legal payload byte count.
- IFG_CYCLES, 12: cycles parser_enable is held low after each frame.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_dv  in  1  byte valid; high for every byte of a frame, low between frames.
- preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid  in  1 each  parser field pulses.
- parser_enable  out  1  enable to the header parser; low synchronously clears the parser.
- busy  out  1  high in any state other than IDLE.
- hdr_ok  out  1  one-cycle pulse when type_length_valid is accepted.
- frame_done  out  1  one-cycle pulse for a good frame.
- frame_err  out  1  one-cycle pulse for an errored frame.
- err_code  out  3  0 NONE, 1 NO_SFD, 2 HDR_TIMEOUT, 3 TRUNC, 4 RUNT, 5 GIANT; held until the next frame_done or frame_err.
- payload_len  out  11  payload byte count; saturates at 2047; held like err_code.
- good_cnt, err_cnt  out  16 each  saturating frame statistics (see Configuration).

## Operation
- States: IDLE, HUNT, DST, SRC, TYPE, PAYLOAD, GAP.
- IDLE: rx_dv=1 -> HUNT. parser_enable=1 from HUNT entry through TYPE.
- HUNT: preamble_valid -> DST. rx_dv=0 -> error NO_SFD.
- DST / SRC / TYPE: the expected pulse moves to the next stage and clears the deadline counter. Otherwise the counter increments each cycle. Counter reaching FIELD_TO -> HDR_TIMEOUT. rx_dv=0 -> TRUNC.
- Priority within any cycle: expected pulse, then rx_dv=0, then timeout.
- TYPE accepting type_length_valid: hdr_ok pulses and the state moves to PAYLOAD with payload_len cleared. Unexpected pulses (wrong stage) are ignored.
- PAYLOAD: parser_enable=0. Each cycle with rx_dv=1 increments payload_len, saturating. The first cycle with rx_dv=0 ends the frame:
  - len < MIN_PAYLOAD -> RUNT.
  - len > MAX_PAYLOAD -> GIANT.
  - otherwise frame_done with err_code=NONE.
- Every error pulses frame_err with err_code and goes to GAP. Errors never produce frame_done.
- GAP: parser_enable=0 for IFG_CYCLES cycles, then IDLE. rx_dv is ignored in GAP.
- If rx_dv is already high on return to IDLE, the block enters HUNT mid-frame. That frame ends as NO_SFD unless a new preamble appears.
- Reset, including mid-frame: state IDLE; all outputs 0; err_code 0; payload_len 0; counters 0.

## Timing
- All outputs are registered.
- hdr_ok asserts the cycle after type_length_valid is sampled high in TYPE.
- frame_done / frame_err assert the cycle after the terminating condition is sampled. err_code and payload_len are valid in the same cycle.
- parser_enable falls the cycle after PAYLOAD or GAP is entered, so the parser sees at least one low cycle per frame.
- Back-to-back frame minimum spacing: IFG_CYCLES + 1 cycles after frame_done / frame_err before HUNT is re-entered.

## Configuration
- ETH_RX_STATS_EN defined:
  - good_cnt increments on each frame_done.
  - err_cnt increments on each frame_err.
  - Both saturate at 16'hFFFF and clear only on reset.
- Not defined: the ports remain and are tied to 0; no counter logic is synthesized.

## Structure
- Package eth_rx_pkg holds:
  - state enum eth_rx_state_t;
  - err_code constants (ERR_NONE..ERR_GIANT);
  - width constants (PAYLOAD_LEN_W=11, STAT_W=16).
- One sub-module, eth_sat_counter (width parameter, clear, increment, saturation). It is instantiated for payload_len, and for good_cnt/err_cnt under ETH_RX_STATS_EN.

## Test plan
- Good frame: 8 preamble bytes 55×7,D5; dst 01..06; src FF..FA; type 08,00; 46 payload bytes; rx_dv drops. Expect hdr_ok once, frame_done, err_code=0, payload_len=46, then parser_enable low for exactly 12 cycles.
- Runt and giant: 45 payload bytes -> frame_err, err_code=4, len=45. 1501 bytes -> err_code=5, len=1501. 2100 bytes -> len saturates at 2047.
- Header timeout: after preamble_valid, withhold dst_addr_valid for 8 cycles with rx_dv high. Expect frame_err with err_code=2 and GAP entered.
- Truncation: rx_dv drops in SRC. Expect err_code=3. A frame with no preamble match until rx_dv drops expects err_code=1.
- Simultaneous events: type_length_valid and rx_dv=0 in the same cycle. Expect hdr_ok, then RUNT with len=0.
- Reset mid-PAYLOAD: assert reset_n=0 asynchronously. All outputs read 0 immediately; the next good frame completes normally. With ETH_RX_STATS_EN, 3 good + 2 bad frames -> good_cnt=3, err_cnt=2.
